// File: rtl/game_pkg.sv
// Shared game-supervisor types and default geometry constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    // IDLE/PLAY/OVER encodings are fixed by the existing renderer; PAUSE takes the spare code.
    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_OVER  = 2'd2,
        GS_PAUSE = 2'd3
    } game_state_t;

    // Ground line y and sprite height in pixels.
    localparam int EARTH_DEF    = 480;
    localparam int DOODLE_H_DEF = 70;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one raw asynchronous button into the clk domain.
// Latency: 2 clk from din to dout.
// Backpressure: none; samples every clock.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two-stage shift; the first stage may go metastable, the second gives it a clock to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/game_control.sv
// Frame-rate game supervisor: game state machine plus per-frame horizontal speed with accel/friction/saturation.
// Latency: state/speed update on the tick edge; delta_x follows one clk later; restart pulses on the tick edge.
// Backpressure: none; button presses between ticks or outside listed transitions are dropped.
module game_control
    import game_pkg::*;
#(
    parameter int FPS       = 60,
    parameter int CLK       = 25_000_000,
    parameter int EARTH     = EARTH_DEF,
    parameter int DOODLE_H  = DOODLE_H_DEF,
    parameter int DX_W      = 9,
    parameter int ACCEL     = 1,
    parameter int FRICTION  = 1,
    parameter int MAX_SPEED = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(CLK/FPS):0] fps_counter,
    input  logic                     button_left,
    input  logic                     button_right,
    input  logic                     button_pause,
    input  logic [9:0]               doodle_y,
    output logic signed [DX_W-1:0]   delta_x,
    output logic [1:0]               game_state,
    output logic                     restart
);

    // Speed arithmetic runs two bits wider than delta_x so a step past the limit
    // can be seen and clamped before it could wrap.
    localparam int SW = DX_W + 2;
    localparam logic signed [SW-1:0] ACC_S  = SW'(ACCEL);
    localparam logic signed [SW-1:0] FRIC_S = SW'(FRICTION);
    localparam logic signed [SW-1:0] MAX_S  = SW'(MAX_SPEED);
    localparam logic signed [SW-1:0] MIN_S  = -MAX_S;
    localparam logic signed [SW-1:0] ZERO_S = '0;

    // One frame of speed evolution: push toward the held direction with saturation,
    // or decay toward zero without ever crossing it when no single direction is held.
    function automatic logic signed [SW-1:0] step_speed(
        input logic signed [SW-1:0] cur,
        input logic                 go_right,
        input logic                 go_left
    );
        logic signed [SW-1:0] t;
        t = cur;
        if (go_right && !go_left) begin
            t = cur + ACC_S;
            if (t > MAX_S) t = MAX_S;
        end else if (go_left && !go_right) begin
            t = cur - ACC_S;
            if (t < MIN_S) t = MIN_S;
        end else if (cur > ZERO_S) begin
            t = cur - FRIC_S;
            if (t < ZERO_S) t = ZERO_S;
        end else if (cur < ZERO_S) begin
            t = cur + FRIC_S;
            if (t > ZERO_S) t = ZERO_S;
        end
        return t;
    endfunction

    logic sync_left;
    logic sync_right;
    logic sync_pause;

    btn_sync u_sync_left (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (button_left),
        .dout  (sync_left)
    );

    btn_sync u_sync_right (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (button_right),
        .dout  (sync_right)
    );

    btn_sync u_sync_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (button_pause),
        .dout  (sync_pause)
    );

    game_state_t              state;
    game_state_t              state_nxt;
    logic signed [DX_W-1:0]   speed;
    logic signed [SW-1:0]     speed_ext;
    logic signed [SW-1:0]     speed_nxt;
    logic                     pause_prev;
    logic                     pause_prev_nxt;
    logic                     restart_nxt;
    logic signed [DX_W-1:0]   delta_nxt;
    logic                     tick;
    logic                     pause_rise;
    logic [10:0]              doodle_bottom;
    logic                     hit_ground;

    assign tick          = &fps_counter;
    // pause_prev only moves on tick, so the edge is measured frame-to-frame.
    assign pause_rise    = sync_pause & ~pause_prev;
    assign speed_ext     = {{2{speed[DX_W-1]}}, speed};
    // 11 bits holds 1023 + sprite height without overflow.
    assign doodle_bottom = {1'b0, doodle_y} + 11'(DOODLE_H);
    assign hit_ground    = (doodle_bottom >= 11'(EARTH));
    assign game_state    = state;

    // Next-state, next-speed and pulse decode; everything holds unless this is a tick.
    always_comb begin
        state_nxt      = state;
        speed_nxt      = speed_ext;
        pause_prev_nxt = pause_prev;
        restart_nxt    = 1'b0;
        delta_nxt      = (state == GS_PLAY) ? speed : '0;

        if (tick) begin
            pause_prev_nxt = sync_pause;
            unique case (state)
                GS_IDLE: begin
                    // Speed is already zero here; the first step lands on the following tick.
                    if (sync_left || sync_right) begin
                        state_nxt = GS_PLAY;
                        speed_nxt = ZERO_S;
                    end
                end
                GS_PLAY: begin
                    // Hitting the ground wins over a simultaneous pause press.
                    if (hit_ground) begin
                        state_nxt = GS_OVER;
                        speed_nxt = ZERO_S;
                    end else if (pause_rise) begin
                        state_nxt = GS_PAUSE;
                    end else begin
                        speed_nxt = step_speed(speed_ext, sync_right, sync_left);
                    end
                end
                GS_PAUSE: begin
                    // Speed is frozen while paused and resumes unchanged.
                    if (pause_rise) begin
                        state_nxt = GS_PLAY;
                    end
                end
                GS_OVER: begin
                    if (pause_rise) begin
                        state_nxt   = GS_IDLE;
                        speed_nxt   = ZERO_S;
                        restart_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = GS_IDLE;
                    speed_nxt = ZERO_S;
                end
            endcase
        end
    end

    // All supervisor state; reset clears outputs immediately without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GS_IDLE;
            speed      <= '0;
            pause_prev <= 1'b0;
            restart    <= 1'b0;
            delta_x    <= '0;
        end else begin
            state      <= state_nxt;
            speed      <= speed_nxt[DX_W-1:0];
            pause_prev <= pause_prev_nxt;
            restart    <= restart_nxt;
            delta_x    <= delta_nxt;
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: directed vector table, reset corner, randomized frames vs. model.
// Latency: each frame holds inputs 3 clk, ticks once, then samples 2 clk later.
// Backpressure: n/a.
module tb_game_control;

    localparam int FPS       = 60;
    localparam int CLKF      = 25_000_000;
    localparam int EARTH     = 480;
    localparam int DOODLE_H  = 70;
    localparam int DX_W      = 9;
    localparam int ACCEL     = 1;
    localparam int FRICTION  = 1;
    localparam int MAX_SPEED = 5;
    localparam int FCW       = $clog2(CLKF/FPS) + 1;

    logic                   clk;
    logic                   rst_n;
    logic [FCW-1:0]         fps_counter;
    logic                   button_left;
    logic                   button_right;
    logic                   button_pause;
    logic [9:0]             doodle_y;
    logic signed [DX_W-1:0] delta_x;
    logic [1:0]             game_state;
    logic                   restart;

    int checks   = 0;
    int failures = 0;
    int rcnt;

    game_control #(
        .FPS(FPS), .CLK(CLKF), .EARTH(EARTH), .DOODLE_H(DOODLE_H), .DX_W(DX_W),
        .ACCEL(ACCEL), .FRICTION(FRICTION), .MAX_SPEED(MAX_SPEED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fps_counter  (fps_counter),
        .button_left  (button_left),
        .button_right (button_right),
        .button_pause (button_pause),
        .doodle_y     (doodle_y),
        .delta_x      (delta_x),
        .game_state   (game_state),
        .restart      (restart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       l;
        logic       r;
        logic       p;
        logic [9:0] y;
        int         st;
        int         dx;
        int         rs;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic l, input logic r, input logic p, input int y,
                                input int st, input int dx, input int rs);
        vec_t v;
        v.l = l; v.r = r; v.p = p; v.y = 10'(y);
        v.st = st; v.dx = dx; v.rs = rs;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Holds inputs long enough to cross the synchronisers, issues one tick,
    // counts restart cycles and leaves delta_x settled. Called aligned to a negedge.
    task automatic frame(input logic l, input logic r, input logic p, input logic [9:0] y);
        button_left  = l;
        button_right = r;
        button_pause = p;
        doodle_y     = y;
        repeat (3) @(negedge clk);
        fps_counter = '1;
        @(negedge clk);
        fps_counter = '0;
        rcnt = 0;
        if (restart) rcnt++;
        repeat (2) begin
            @(negedge clk);
            if (restart) rcnt++;
        end
    endtask

    // Behavioural reference: game rules on plain integers.
    int m_state, m_speed, m_rs;
    bit m_prev;

    task automatic model_reset();
        m_state = 0; m_speed = 0; m_prev = 0; m_rs = 0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit p, input int y);
        bit rise;
        int d;
        rise   = p && !m_prev;
        m_prev = p;
        m_rs   = 0;
        d      = int'(r) - int'(l);
        case (m_state)
            0: if (l || r) begin m_state = 1; m_speed = 0; end
            1: begin
                if (y + DOODLE_H >= EARTH) begin
                    m_state = 2; m_speed = 0;
                end else if (rise) begin
                    m_state = 3;
                end else if (d != 0) begin
                    m_speed = m_speed + d * ACCEL;
                    if (m_speed > MAX_SPEED)  m_speed = MAX_SPEED;
                    if (m_speed < -MAX_SPEED) m_speed = -MAX_SPEED;
                end else if (m_speed > 0) begin
                    m_speed = (m_speed > FRICTION) ? m_speed - FRICTION : 0;
                end else if (m_speed < 0) begin
                    m_speed = (-m_speed > FRICTION) ? m_speed + FRICTION : 0;
                end
            end
            3: if (rise) m_state = 1;
            2: if (rise) begin m_state = 0; m_speed = 0; m_rs = 1; end
            default: m_state = 0;
        endcase
    endtask

    initial begin
        rst_n        = 1'b0;
        fps_counter  = '0;
        button_left  = 1'b0;
        button_right = 1'b0;
        button_pause = 1'b0;
        doodle_y     = '0;

        // hold right from IDLE, ramp to saturation
        vq.push_back(mk(0,1,0,0, 1,0,0));
        vq.push_back(mk(0,1,0,0, 1,1,0));
        vq.push_back(mk(0,1,0,0, 1,2,0));
        vq.push_back(mk(0,1,0,0, 1,3,0));
        vq.push_back(mk(0,1,0,0, 1,4,0));
        vq.push_back(mk(0,1,0,0, 1,5,0));
        vq.push_back(mk(0,1,0,0, 1,5,0));
        // friction down to zero and no further
        vq.push_back(mk(0,0,0,0, 1,4,0));
        vq.push_back(mk(0,0,0,0, 1,3,0));
        vq.push_back(mk(0,0,0,0, 1,2,0));
        vq.push_back(mk(0,0,0,0, 1,1,0));
        vq.push_back(mk(0,0,0,0, 1,0,0));
        vq.push_back(mk(0,0,0,0, 1,0,0));
        // left from rest
        vq.push_back(mk(1,0,0,0, 1,-1,0));
        vq.push_back(mk(1,0,0,0, 1,-2,0));
        // back up to +2, then both buttons -> friction
        vq.push_back(mk(0,1,0,0, 1,-1,0));
        vq.push_back(mk(0,1,0,0, 1,0,0));
        vq.push_back(mk(0,1,0,0, 1,1,0));
        vq.push_back(mk(0,1,0,0, 1,2,0));
        vq.push_back(mk(1,1,0,0, 1,1,0));
        vq.push_back(mk(1,1,0,0, 1,0,0));
        vq.push_back(mk(1,1,0,0, 1,0,0));
        // speed 3, pause, direction ignored while paused, resume with held speed
        vq.push_back(mk(0,1,0,0, 1,1,0));
        vq.push_back(mk(0,1,0,0, 1,2,0));
        vq.push_back(mk(0,1,0,0, 1,3,0));
        vq.push_back(mk(0,0,1,0, 3,0,0));
        vq.push_back(mk(1,0,0,0, 3,0,0));
        vq.push_back(mk(0,0,1,0, 1,3,0));
        // one pixel above ground keeps playing
        vq.push_back(mk(0,0,0,409, 1,2,0));
        vq.push_back(mk(0,0,0,409, 1,1,0));
        // ground contact and pause on the same tick -> OVER
        vq.push_back(mk(0,0,1,410, 2,0,0));
        vq.push_back(mk(0,0,0,0, 2,0,0));
        vq.push_back(mk(0,1,0,0, 2,0,0));
        vq.push_back(mk(0,0,1,0, 0,0,1));
        vq.push_back(mk(0,0,1,0, 0,0,0));
        // new game starts from zero speed
        vq.push_back(mk(0,1,0,0, 1,0,0));
        vq.push_back(mk(0,1,0,0, 1,1,0));
        vq.push_back(mk(0,1,0,0, 1,2,0));
        vq.push_back(mk(0,1,0,0, 1,3,0));

        repeat (3) @(negedge clk);
        check("reset_state", int'(game_state), 0);
        check("reset_dx", int'(delta_x), 0);
        check("reset_restart", int'(restart), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            frame(vq[i].l, vq[i].r, vq[i].p, vq[i].y);
            if (int'(game_state) != vq[i].st || int'(delta_x) != vq[i].dx || rcnt != vq[i].rs)
                $display("vector %0d differs", i);
            check("vec_state", int'(game_state), vq[i].st);
            check("vec_dx", int'(delta_x), vq[i].dx);
            check("vec_restart", rcnt, vq[i].rs);
        end

        // Asynchronous reset mid-cycle while playing at speed 3.
        button_right = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", int'(game_state), 0);
        check("async_rst_dx", int'(delta_x), 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 0, 0, 0);
        check("post_rst_idle", int'(game_state), 0);
        frame(1, 0, 0, 0);
        check("post_rst_play", int'(game_state), 1);
        check("post_rst_dx", int'(delta_x), 0);
        frame(1, 0, 0, 0);
        check("post_rst_step", int'(delta_x), -1);

        // Randomized frames against the model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            bit l, r, p;
            int y;
            l = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            p = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) y = 405 + $urandom_range(0, 10);
            else                           y = $urandom_range(0, 300);
            frame(l, r, p, 10'(y));
            model_frame(l, r, p, y);
            check("rnd_state", int'(game_state), m_state);
            check("rnd_dx", int'(delta_x), (m_state == 1) ? m_speed : 0);
            check("rnd_restart", rcnt, m_rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
